// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the CPU, a debug port and a wipe sequencer
module dm_port_arbiter #(
   parameter int DEPTH = 1024,
   parameter int AW = 10,
   parameter int STARVE_MAX = 8
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
   input  logic          cpu_str,
   input  logic          cpu_ld,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [31:0]   dbg_wdata,
   output logic          dbg_ack,
   output logic [31:0]   dbg_rdata,
   input  logic          wipe_start,
   output logic          wipe_busy,
   output logic          wipe_done,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_str,
   input  logic [31:0]   mem_rdata
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   typedef enum logic {IDLE, WIPE} state_t;
   state_t state, state_nxt;
   logic [AW-1:0] ptr;
   logic [SW-1:0] starve;
   logic pend, wiping, last, dbg_ok, cpu_act, force_dbg, grant_cpu, grant_dbg;
   always_ff @(posedge clk)
      if (!clr_n) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = (state == IDLE) ? (wipe_start ? WIPE : IDLE) : (last ? IDLE : WIPE);
   // Nothing owns the port while clr_n is low, so reset never writes memory.
   always_comb begin
      wiping = clr_n && state == WIPE;
      last = wiping && ptr == AW'(DEPTH - 1);
      dbg_ok = dbg_req && !pend;
      cpu_act = cpu_ld || cpu_str;
      force_dbg = dbg_ok && starve == SW'(STARVE_MAX);
      grant_cpu = clr_n && !wiping && cpu_act && !force_dbg;
      grant_dbg = clr_n && !wiping && dbg_ok && (force_dbg || !cpu_act);
      mem_addr = wiping ? {{(30 - AW){1'b0}}, ptr, 2'b00} :
                 grant_dbg ? {{(30 - AW){1'b0}}, dbg_addr, 2'b00} :
                 grant_cpu ? cpu_addr : '0;
      mem_wdata = grant_dbg ? dbg_wdata : grant_cpu ? cpu_wdata : '0;
      mem_str = wiping || (grant_dbg && dbg_we) || (grant_cpu && cpu_str);
      cpu_stall = wiping || (grant_dbg && cpu_act);
      wipe_busy = wiping;
      dbg_ack = pend;
      cpu_rdata = mem_rdata;
   end
   always_ff @(posedge clk)
      if (!clr_n) begin
         ptr <= '0;
         starve <= '0;
         pend <= 1'b0;
         dbg_rdata <= '0;
         wipe_done <= 1'b0;
      end else begin
         ptr <= wiping ? ptr + AW'(1) : '0;
         pend <= grant_dbg;
         wipe_done <= last;
         if (grant_dbg) dbg_rdata <= mem_rdata;
         starve <= grant_dbg ? '0 :
                   (grant_cpu && dbg_ok && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
      end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: drives the arbiter against a behavioural 1024x32 memory and scoreboards read data
module tb_dm_port_arbiter;
   logic clk = 1'b0, clr_n;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic cpu_str, cpu_ld, cpu_stall, dbg_req, dbg_we, dbg_ack, wipe_start, wipe_busy, wipe_done, mem_str;
   logic [9:0] dbg_addr;
   logic [31:0] mem [0:1023];
   logic [31:0] sb [$];
   int n_chk = 0, n_fail = 0;
   int busy, bad, done, done_at, acked;

   always #5 clk = ~clk;

   dm_port_arbiter dut (
      .clk(clk), .clr_n(clr_n),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_str(cpu_str), .cpu_ld(cpu_ld),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .wipe_start(wipe_start), .wipe_busy(wipe_busy), .wipe_done(wipe_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_str(mem_str), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[11:2]];
   always @(posedge clk)
      if (mem_str) mem[mem_addr[11:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cpu_st(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cpu_ld = 0; cpu_str = 1; cpu_addr = a; cpu_wdata = d; dbg_req = 0;
      #1;
      chk("st_str", 32'(mem_str), 1);
      chk("st_stall", 32'(cpu_stall), 0);
   endtask

   task automatic cpu_load(input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      cpu_ld = 1; cpu_str = 0; cpu_addr = a; dbg_req = 0;
      sb.push_back(exp);
      #1;
      chk("ld_stall", 32'(cpu_stall), 0);
      chk("ld_rdata", cpu_rdata, sb.pop_front());
   endtask

   task automatic dbg_op(input logic we, input logic [9:0] a, input logic [31:0] wd, input logic [31:0] exp);
      int n;
      @(negedge clk);
      cpu_ld = 0; cpu_str = 0; dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
      sb.push_back(exp);
      #1;
      chk("dbg_str", 32'(mem_str), 32'(we));
      n = 0;
      while (!dbg_ack && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("dbg_lat", n, 1);
      chk("dbg_rdata", dbg_rdata, sb.pop_front());
      @(negedge clk);
      dbg_req = 0;
   endtask

   initial begin
      clr_n = 0; cpu_ld = 1; cpu_str = 1; cpu_addr = 32'h40; cpu_wdata = '1;
      dbg_req = 1; dbg_we = 1; dbg_addr = 10'd7; dbg_wdata = '1; wipe_start = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_str", 32'(mem_str), 0);
      chk("rst_stall", 32'(cpu_stall), 0);
      chk("rst_ack", 32'(dbg_ack), 0);
      chk("rst_rdata", dbg_rdata, 0);
      chk("rst_busy", 32'(wipe_busy), 0);
      chk("rst_done", 32'(wipe_done), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      clr_n = 1; cpu_ld = 0; cpu_str = 0; dbg_req = 0; dbg_we = 0; wipe_start = 0;
      #1;
      chk("idle_str0", 32'(mem_str), 0);
      @(negedge clk);
      #1;
      chk("idle_str1", 32'(mem_str), 0);
      chk("idle_busy", 32'(wipe_busy), 0);

      cpu_st(32'h10, 32'hDEADBEEF);
      cpu_load(32'h10, 32'hDEADBEEF);

      dbg_op(1, 10'd4, 32'h1234, 32'hDEADBEEF);
      dbg_op(0, 10'd4, 32'h0, 32'h1234);
      cpu_load(32'h10, 32'h1234);

      // CPU loads every cycle; debug should be forced in on the ninth cycle
      @(negedge clk);
      cpu_ld = 1; cpu_str = 0; cpu_addr = 32'h20; dbg_req = 1; dbg_we = 0; dbg_addr = 10'd4;
      sb.push_back(32'h1234);
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) @(negedge clk);
         #1;
         chk("starve_stall", 32'(cpu_stall), 32'(i == 9));
         chk("starve_ack", 32'(dbg_ack), 32'(i == 10));
         if (i == 9) chk("starve_addr", mem_addr, 32'h10);
      end
      chk("starve_rdata", dbg_rdata, sb.pop_front());
      @(negedge clk);
      dbg_req = 0; cpu_ld = 0;

      cpu_st(32'h0, 32'h11);
      cpu_st(32'h14, 32'h55);
      cpu_st(32'hFFC, 32'h3FF);
      @(negedge clk);
      cpu_str = 0; cpu_ld = 0; wipe_start = 1;
      #1;
      chk("ws_busy", 32'(wipe_busy), 0);
      busy = 0; bad = 0; done = 0; done_at = 0; acked = 0;
      for (int i = 1; i <= 1040; i++) begin
         @(negedge clk);
         wipe_start = (i == 500);
         if (i == 100) begin
            dbg_req = 1; dbg_we = 0; dbg_addr = 10'd5;
            sb.push_back(32'h0);
         end
         #1;
         if (wipe_busy) begin
            busy++;
            if (!cpu_stall) bad++;
         end
         if (wipe_done) begin
            done++;
            done_at = i;
         end
         if (i == 5) begin
            chk("wipe_addr", mem_addr, 32'h10);
            chk("wipe_wdata", mem_wdata, 0);
            chk("wipe_str", 32'(mem_str), 1);
         end
         if (dbg_ack) begin
            acked = i;
            chk("wipe_dbg_rdata", dbg_rdata, sb.pop_front());
            dbg_req = 0;
         end
      end
      chk("wipe_busy_cycles", busy, 1024);
      chk("wipe_stall_gaps", bad, 0);
      chk("wipe_done_count", done, 1);
      chk("wipe_done_cycle", done_at, 1025);
      chk("wipe_dbg_ack_cycle", acked, 1026);
      cpu_load(32'h0, 0);
      cpu_load(32'h14, 0);
      cpu_load(32'hFFC, 0);
      cpu_load(32'h10, 0);

      cpu_st(32'd1196, 32'hA299);
      cpu_st(32'd1200, 32'hB300);
      cpu_st(32'd2800, 32'hC700);
      @(negedge clk);
      cpu_str = 0; wipe_start = 1;
      done = 0;
      for (int i = 1; i <= 320; i++) begin
         @(negedge clk);
         wipe_start = 0;
         clr_n = !(i == 301);
         #1;
         if (i == 300) chk("abort_prev_addr", mem_addr, 32'd1196);
         if (i == 301) chk("abort_str", 32'(mem_str), 0);
         if (i == 302) chk("abort_busy", 32'(wipe_busy), 0);
         if (wipe_done) done++;
      end
      chk("abort_no_done", done, 0);
      cpu_load(32'd1196, 0);
      cpu_load(32'd1200, 32'hB300);
      cpu_load(32'd2800, 32'hC700);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory (1024 x 32-bit words, word index = addr[11:2], combinational read, write on posedge clk when str=1) between three masters:
  - the CPU load/store path;
  - a board-side debug port, used for inspecting and poking words from switches/buttons;
  - an internal wipe sequencer that zeroes the whole memory.
- Sits between the CPU datapath and the memory. It drives the memory's addr/datain/str and stalls the CPU when the CPU loses the port.

Parameters:
- DEPTH, 1024: number of 32-bit words in the data memory; the wipe covers words 0..DEPTH-1.
- AW, 10: word-index width of the debug address; must satisfy 2^AW >= DEPTH.
- STARVE_MAX, 8: number of consecutive CPU-won cycles with debug pending, after which debug is forced a slot.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr_n  in  1  synchronous active-low reset.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_str  in  1  CPU store enable.
- cpu_ld  in  1  CPU load enable.
- cpu_rdata  out  32  load data; pass-through of mem_rdata.
- cpu_stall  out  1  CPU must hold its PC and its inputs this cycle.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  debug word index.
- dbg_wdata  in  32  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  32  registered debug read data.
- wipe_start  in  1  starts the wipe sequence.
- wipe_busy  out  1  wipe in progress.
- wipe_done  out  1  one-cycle pulse when the wipe finishes.
- mem_addr  out  32  to memory addr; always a byte address.
- mem_wdata  out  32  to memory datain.
- mem_str  out  1  to memory str.
- mem_rdata  in  32  from memory dataout (combinational).

Behaviour:
- Reset (clr_n=0 at posedge):
  - state=IDLE; wipe pointer=0; starve counter=0; pending-ack flag=0.
  - dbg_ack=0, dbg_rdata=0, wipe_busy=0, wipe_done=0, cpu_stall=0, mem_str=0.
  - Reset during a wipe aborts it; no wipe_done pulse is produced.
- States: IDLE (normal arbitration) and WIPE.
- Owner selection is combinational from registered state, evaluated each cycle in this priority order:
  1. WIPE.
  2. Forced debug: dbg_req=1, no ack pending, and starve counter = STARVE_MAX.
  3. CPU, if cpu_ld or cpu_str.
  4. Debug: dbg_req=1 and no ack pending.
  5. None.
- Per-owner drive:
  - CPU owner: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_str=cpu_str; cpu_stall=0.
  - Debug owner: mem_addr={dbg_addr zero-extended, 2'b00}, mem_wdata=dbg_wdata, mem_str=dbg_we. cpu_stall=1 only if the CPU has ld/str active.
  - WIPE owner: mem_addr={ptr,2'b00}, mem_wdata=0, mem_str=1; cpu_stall=1 every cycle.
  - No owner: mem_str=0.
- cpu_rdata = mem_rdata always. It is valid only when cpu_stall=0 and cpu_ld=1.
- Debug completion timing:
  - The access is performed in cycle T.
  - At the end of T, dbg_rdata captures mem_rdata (for a write it captures the old word) and the pending-ack flag is set.
  - dbg_ack=1 in T+1 only.
  - Debug is not grantable in T+1, so debug throughput is at most one access per two cycles.
  - The pending flag clears at the end of T+1.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each cycle where the CPU owns the port while dbg_req=1 and no ack is pending.
  - Clears on any debug grant.
  - Holds its value during WIPE.
- Wipe sequence:
  - wipe_start=1 in IDLE → WIPE at the next edge, with ptr=0 and wipe_busy=1.
  - Each WIPE cycle writes 0 to word ptr, then ptr increments.
  - After the cycle that writes word DEPTH-1: return to IDLE, wipe_busy=0, and wipe_done=1 for exactly one cycle.
  - Total duration is DEPTH cycles.
  - wipe_start while busy is ignored.
- Simultaneous events:
  - wipe_start in a cycle where debug is granted: the debug access completes and its ack still pulses, during the first WIPE cycle.
  - A debug request pending during the wipe waits and is served after it.
  - cpu_ld and cpu_str both 1 are treated as a store.

Test Plan:
- Reset: clr_n=0 for 2 cycles with all inputs active → every output 0 and mem_str=0. After release with idle inputs, mem_str stays 0.
- CPU store/load: cpu_str=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF, then cpu_ld at 0x10 → mem_str=1 in cycle 1 and cpu_rdata=0xDEADBEEF in cycle 2. cpu_stall=0 throughout.
- Debug read/write with the CPU idle:
  - Write dbg_addr=4, data=0x1234 → dbg_ack one cycle later.
  - Then read dbg_addr=4 → dbg_rdata=0x00001234 with ack.
  - Word 4 is then visible to a CPU load at 0x10.
- Starvation, STARVE_MAX=8: CPU issues loads every cycle while dbg_req is held → debug is granted on cycle 9 with cpu_stall=1 that cycle only, and ack on cycle 10.
- Wipe: preload words 0, 5 and 1023 with nonzero values; pulse wipe_start.
  - wipe_busy=1 for exactly 1024 cycles and cpu_stall=1 throughout.
  - wipe_done pulses once.
  - Words 0, 5 and 1023 read 0.
  - A second wipe_start mid-wipe does not extend the sequence.
- Reset mid-wipe at ptr=300 → IDLE immediately, wipe_done never pulses, words ≥300 keep their old contents.
